// File: rtl/display_7_seg_pkg.sv
// Segment encodings for the 7-segment mux driver, active-high, bit6 = a ... bit0 = g.
package display_7_seg_pkg;

    localparam logic [6:0] SEG_0    = 7'h7E;
    localparam logic [6:0] SEG_1    = 7'h30;
    localparam logic [6:0] SEG_2    = 7'h6D;
    localparam logic [6:0] SEG_3    = 7'h79;
    localparam logic [6:0] SEG_4    = 7'h33;
    localparam logic [6:0] SEG_5    = 7'h5B;
    localparam logic [6:0] SEG_6    = 7'h5F;
    localparam logic [6:0] SEG_7    = 7'h70;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h7B;
    localparam logic [6:0] SEG_A    = 7'h77;
    localparam logic [6:0] SEG_B    = 7'h1F;
    localparam logic [6:0] SEG_C    = 7'h4E;
    localparam logic [6:0] SEG_D    = 7'h3D;
    localparam logic [6:0] SEG_E    = 7'h4F;
    localparam logic [6:0] SEG_F    = 7'h47;
    localparam logic [6:0] SEG_DASH = 7'h01;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational nibble-to-segment decoder; non-decimal nibbles show a dash unless hex mode is on.
module seg7_decoder
    import display_7_seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            case (nibble)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = hex_mode ? SEG_A : SEG_DASH;
                4'hB: seg = hex_mode ? SEG_B : SEG_DASH;
                4'hC: seg = hex_mode ? SEG_C : SEG_DASH;
                4'hD: seg = hex_mode ? SEG_D : SEG_DASH;
                4'hE: seg = hex_mode ? SEG_E : SEG_DASH;
                4'hF: seg = hex_mode ? SEG_F : SEG_DASH;
                default: seg = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/display_7_seg_mux.sv
// Time-multiplexed N-digit 7-segment driver with ghosting guard, leading-zero
// blanking and frame-atomic value loading through a shadow register.
module display_7_seg_mux
    import display_7_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int CLKS_PER_DIGIT = 25000,
    parameter int BLANK_CLKS     = 250,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [4*NUM_DIGITS-1:0] i_Digits,
    input  logic [NUM_DIGITS-1:0]   i_Dp,
    input  logic                    i_Load,
    input  logic                    i_Hex_Mode,
    input  logic                    i_Blank_Lead,
    output logic [6:0]              o_Seg,
    output logic                    o_Dp,
    output logic [NUM_DIGITS-1:0]   o_Digit_En,
    output logic                    o_Frame_Start
);

    localparam int CNT_W = $clog2(CLKS_PER_DIGIT);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CLKS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_POL = (DIG_ACTIVE_LOW != 0);

    logic [CNT_W-1:0]        cnt_p0;
    logic [IDX_W-1:0]        idx_p0;
    logic                    first_p0;
    logic [4*NUM_DIGITS-1:0] shadow_dig;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] frame_dig;
    logic [NUM_DIGITS-1:0]   frame_dp;

    logic [6:0]              seg_p1;
    logic                    dp_p1;
    logic [NUM_DIGITS-1:0]   en_p1;
    logic                    fs_p1;

    logic                    slot_end;
    logic                    frame_end;
    logic                    guard;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_blank;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic [6:0]              dec_seg;

    assign slot_end  = (cnt_p0 == CNT_LAST);
    assign frame_end = slot_end && (idx_p0 == IDX_LAST);
    assign guard     = (cnt_p0 < CNT_BLANK);

    // Walk from the most significant digit down so zero_run is "all digits from here up are zero".
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        zero_run  = 1'b1;
        dig_sel   = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (frame_dig[4*k +: 4] == 4'h0);
            if (idx_p0 == IDX_W'(k)) begin
                cur_nib    = frame_dig[4*k +: 4];
                cur_dp     = frame_dp[k];
                cur_blank  = i_Blank_Lead && (k != 0) && zero_run;
                dig_sel[k] = 1'b1;
            end
        end
    end

    seg7_decoder u_dec (
        .nibble   (cur_nib),
        .hex_mode (i_Hex_Mode),
        .blank    (cur_blank),
        .seg      (dec_seg)
    );

    // Stage p0 -> p1: scan state advance and registered pin drive.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            cnt_p0     <= '0;
            idx_p0     <= '0;
            first_p0   <= 1'b1;
            shadow_dig <= '0;
            shadow_dp  <= '0;
            frame_dig  <= '0;
            frame_dp   <= '0;
            seg_p1     <= {7{SEG_POL}};
            dp_p1      <= SEG_POL;
            en_p1      <= {NUM_DIGITS{DIG_POL}};
            fs_p1      <= 1'b0;
        end else begin
            cnt_p0   <= slot_end ? '0 : cnt_p0 + 1'b1;
            if (slot_end) begin
                idx_p0 <= frame_end ? '0 : idx_p0 + 1'b1;
            end
            first_p0 <= 1'b0;
            if (i_Load) begin
                shadow_dig <= i_Digits;
                shadow_dp  <= i_Dp;
            end
            // Frame only changes on a frame boundary, so a scan never mixes old and new values.
            if (first_p0 || frame_end) begin
                frame_dig <= shadow_dig;
                frame_dp  <= shadow_dp;
            end
            fs_p1 <= first_p0 || frame_end;
            if (guard) begin
                seg_p1 <= {7{SEG_POL}};
                dp_p1  <= SEG_POL;
                en_p1  <= {NUM_DIGITS{DIG_POL}};
            end else begin
                seg_p1 <= dec_seg ^ {7{SEG_POL}};
                dp_p1  <= cur_dp ^ SEG_POL;
                en_p1  <= dig_sel ^ {NUM_DIGITS{DIG_POL}};
            end
        end
    end

    assign o_Seg         = seg_p1;
    assign o_Dp          = dp_p1;
    assign o_Digit_En    = en_p1;
    assign o_Frame_Start = fs_p1;

endmodule

// File: tb/tb_display_7_seg_mux.sv
// Directed bench for display_7_seg_mux: 4 digits, 4 clocks per slot, 1 guard clock, active-low pins.
module tb_display_7_seg_mux;

    logic        clk = 1'b0;
    logic        rst_l;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        load;
    logic        hex_mode;
    logic        blank_lead;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  dig_en;
    logic        frame_start;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    display_7_seg_mux #(
        .NUM_DIGITS     (4),
        .CLKS_PER_DIGIT (4),
        .BLANK_CLKS     (1),
        .SEG_ACTIVE_LOW (1),
        .DIG_ACTIVE_LOW (1)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_L       (rst_l),
        .i_Digits      (digits),
        .i_Dp          (dp_in),
        .i_Load        (load),
        .i_Hex_Mode    (hex_mode),
        .i_Blank_Lead  (blank_lead),
        .o_Seg         (seg),
        .o_Dp          (dp_out),
        .o_Digit_En    (dig_en),
        .o_Frame_Start (frame_start)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load_val(input logic [15:0] d, input logic [3:0] dp);
        digits = d;
        dp_in  = dp;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
    endtask

    task automatic wait_fs();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (frame_start) seen = 1'b1;
        end
        if (!seen) chk("fs_timeout", 32'd0, 32'd1);
    endtask

    // Called at the sample where o_Frame_Start is high; checks the 16 following clocks.
    // e3..e0 are active-high segment patterns; optional load captured at clock ld_j.
    task automatic frame_check(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                               input logic [6:0] e1, input logic [6:0] e0, input logic [3:0] edp,
                               input int ld_j, input logic [15:0] ld_val);
        logic [6:0] e [4];
        logic [3:0] xen;
        logic [6:0] xseg;
        logic       xdp;
        int         slot;
        int         ph;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int j = 1; j <= 16; j++) begin
            if (j == ld_j) begin
                digits = ld_val;
                load   = 1'b1;
            end else begin
                load   = 1'b0;
            end
            @(negedge clk);
            slot = (j - 1) / 4;
            ph   = (j - 1) % 4;
            if (ph == 0) begin
                xen  = 4'hF;
                xseg = 7'h7F;
                xdp  = 1'b1;
            end else begin
                xen  = ~(4'b0001 << slot);
                xseg = ~e[slot];
                xdp  = ~edp[slot];
            end
            chk($sformatf("%s_en%0d", tag, j), dig_en, xen);
            chk($sformatf("%s_seg%0d", tag, j), seg, xseg);
            chk($sformatf("%s_dp%0d", tag, j), dp_out, xdp);
            chk($sformatf("%s_fs%0d", tag, j), frame_start, (j == 16));
        end
        load = 1'b0;
    endtask

    initial begin
        rst_l      = 1'b0;
        digits     = 16'h0;
        dp_in      = 4'h0;
        load       = 1'b0;
        hex_mode   = 1'b0;
        blank_lead = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_en", dig_en, 4'hF);
        chk("rst_dp", dp_out, 1'b1);
        chk("rst_fs", frame_start, 1'b0);

        rst_l = 1'b1;
        @(negedge clk);
        chk("rel1_fs", frame_start, 1'b1);
        chk("rel1_en", dig_en, 4'hF);
        @(negedge clk);
        chk("rel2_en", dig_en, 4'hE);
        chk("rel2_seg", seg, 7'h01);
        chk("rel2_dp", dp_out, 1'b1);

        load_val(16'h1234, 4'h0);
        wait_fs();
        frame_check("f1234", 7'h30, 7'h6D, 7'h79, 7'h33, 4'h0, -1, 16'h0);

        load_val(16'h00A5, 4'b0100);
        wait_fs();
        frame_check("dash", 7'h7E, 7'h7E, 7'h01, 7'h5B, 4'b0100, -1, 16'h0);
        hex_mode = 1'b1;
        frame_check("hexA", 7'h7E, 7'h7E, 7'h77, 7'h5B, 4'b0100, -1, 16'h0);

        blank_lead = 1'b1;
        load_val(16'h0000, 4'h0);
        wait_fs();
        frame_check("blk0", 7'h00, 7'h00, 7'h00, 7'h7E, 4'h0, -1, 16'h0);
        load_val(16'h0105, 4'h0);
        wait_fs();
        frame_check("blk105", 7'h00, 7'h30, 7'h7E, 7'h5B, 4'h0, -1, 16'h0);

        blank_lead = 1'b0;
        frame_check("midld", 7'h7E, 7'h30, 7'h7E, 7'h5B, 4'h0, 7, 16'h9876);
        frame_check("f9876a", 7'h7B, 7'h7F, 7'h70, 7'h5F, 4'h0, 16, 16'h4321);
        frame_check("f9876b", 7'h7B, 7'h7F, 7'h70, 7'h5F, 4'h0, -1, 16'h0);
        frame_check("f4321", 7'h33, 7'h79, 7'h6D, 7'h30, 4'h0, -1, 16'h0);

        repeat (6) @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        chk("mrst_seg", seg, 7'h7F);
        chk("mrst_en", dig_en, 4'hF);
        chk("mrst_dp", dp_out, 1'b1);
        chk("mrst_fs", frame_start, 1'b0);
        rst_l = 1'b1;
        @(negedge clk);
        chk("mrel1_fs", frame_start, 1'b1);
        chk("mrel1_en", dig_en, 4'hF);
        @(negedge clk);
        chk("mrel2_en", dig_en, 4'hE);
        chk("mrel2_seg", seg, 7'h01);
        chk("mrel2_dp", dp_out, 1'b1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
